// File: rtl/cv32e40n_apu_resp_pkg.sv
// cv32e40n_apu_resp_pkg: shared types and constants for the APU responder.
// Default APU widths follow the cv32e40p APU port.
package cv32e40n_apu_resp_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;
    localparam int ERR_FLAG_BIT     = 0;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_RSVD
    } apu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        apu_op_e     op;
        logic [31:0] op0;
        logic [31:0] op1;
    } fifo_entry_t;

endpackage

// File: rtl/cv32e40n_apu_responder_if.sv
// cv32e40n_apu_responder_if: APU request/response channel plus the data memory master port.
// slave is the responder's view; master is the core/memory side.
interface cv32e40n_apu_responder_if
    import cv32e40n_apu_resp_pkg::*;
#(
    parameter int NARGS    = APU_NARGS_CPU,
    parameter int WOP      = APU_WOP_CPU,
    parameter int NDSFLAGS = APU_NDSFLAGS_CPU,
    parameter int NUSFLAGS = APU_NUSFLAGS_CPU
);

    logic [NARGS-1:0][31:0] apu_operands_i;
    logic [WOP-1:0]         apu_op_i;
    logic [NDSFLAGS-1:0]    apu_flags_i;
    logic                   apu_req_i;
    logic                   apu_gnt_o;
    logic                   apu_rvalid_o;
    logic [31:0]            apu_result_o;
    logic [NUSFLAGS-1:0]    apu_flags_o;
    logic                   mem_master_sel;
    logic                   data_req_o;
    logic                   data_we_o;
    logic [3:0]             data_be_o;
    logic [31:0]            data_addr_o;
    logic [31:0]            data_wdata_o;
    logic                   data_gnt_i;
    logic                   data_rvalid_i;
    logic [31:0]            data_rdata_i;

    modport slave (
        input  apu_operands_i, apu_op_i, apu_flags_i, apu_req_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o,
        output mem_master_sel, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
    );

    modport master (
        output apu_operands_i, apu_op_i, apu_flags_i, apu_req_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o,
        input  mem_master_sel, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
    );

endinterface

// File: rtl/cv32e40n_apu_req_fifo.sv
// cv32e40n_apu_req_fifo: in-order request buffer with full/empty/count status.
// DEPTH must be a power of two so the pointers wrap naturally.
module cv32e40n_apu_req_fifo
    import cv32e40n_apu_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  fifo_entry_t              wdata,
    output fifo_entry_t              rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/cv32e40n_apu_responder.sv
// cv32e40n_apu_responder: buffered in-order APU responder executing ALU adds and memory loads/stores.
// APU_RESP_MISALIGN_CHK_EN: misaligned LOAD/STORE responds with an error instead of accessing the bus.
module cv32e40n_apu_responder
    import cv32e40n_apu_resp_pkg::*;
#(
    parameter int NARGS    = APU_NARGS_CPU,
    parameter int WOP      = APU_WOP_CPU,
    parameter int NDSFLAGS = APU_NDSFLAGS_CPU,
    parameter int NUSFLAGS = APU_NUSFLAGS_CPU,
    parameter int LATENCY  = 1,
    parameter int DEPTH    = 4
) (
    input logic                      clk_i,
    input logic                      rst_i,
    cv32e40n_apu_responder_if.slave  apu
);

    state_e                 state;
    state_e                 state_n;
    logic [3:0]             cnt;
    logic [3:0]             cnt_n;
    logic [31:0]            rdata_q;
    fifo_entry_t            head;
    fifo_entry_t            entry;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic [NARGS-1:0][31:0] operands;
    logic [WOP-1:0]         op_in;
    logic [NDSFLAGS-1:0]    flags_in;
    logic                   bad;
    logic                   err;
    logic                   mem_req;
    logic                   pop;
    logic                   unused_ok;

    assign operands  = apu.apu_operands_i;
    assign op_in     = apu.apu_op_i;
    assign flags_in  = apu.apu_flags_i;
    assign entry     = '{op: apu_op_e'(op_in[1:0]), op0: operands[0], op1: operands[1]};
    assign pop       = state == S_RESP;
    assign mem_req   = state == S_MEM_REQ;
    assign unused_ok = ^{flags_in, op_in, operands, count, head.op0[1:0]};

`ifdef APU_RESP_MISALIGN_CHK_EN
    assign bad = (head.op == OP_LOAD || head.op == OP_STORE) && head.op0[1:0] != 2'b00;
`else
    assign bad = 1'b0;
`endif
    assign err = head.op == OP_RSVD || bad;

    cv32e40n_apu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (apu.apu_req_i),
        .pop   (pop),
        .wdata (entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == S_MEM_WAIT && apu.data_rvalid_i && head.op == OP_LOAD) rdata_q <= apu.data_rdata_i;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_n = head.op == OP_ALU ? S_EXEC : (err ? S_RESP : S_MEM_REQ);
                    cnt_n   = 4'(LATENCY - 1);
                end
            end
            S_EXEC: begin
                if (cnt == '0) state_n = S_RESP;
                else cnt_n = cnt - 1'b1;
            end
            S_MEM_REQ:  state_n = apu.data_gnt_i ? S_MEM_WAIT : S_MEM_REQ;
            S_MEM_WAIT: state_n = apu.data_rvalid_i ? S_RESP : S_MEM_WAIT;
            S_RESP:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Response fields are forced to zero outside the strobe so the core never sees stale data.
    always_comb begin
        apu.apu_gnt_o    = !full;
        apu.apu_rvalid_o = pop;
        apu.apu_result_o = '0;
        apu.apu_flags_o  = '0;
        if (pop) begin
            apu.apu_result_o = err ? '0 : head.op == OP_ALU ? head.op0 + head.op1 : head.op == OP_LOAD ? rdata_q : '0;
            apu.apu_flags_o[ERR_FLAG_BIT] = err;
        end
        apu.mem_master_sel = mem_req || state == S_MEM_WAIT;
        apu.data_req_o     = mem_req;
        apu.data_we_o      = mem_req && head.op == OP_STORE;
        apu.data_be_o      = mem_req ? 4'hF : 4'h0;
        apu.data_addr_o    = mem_req ? {head.op0[31:2], 2'b00} : '0;
        apu.data_wdata_o   = mem_req ? head.op1 : '0;
    end

endmodule

// File: tb/tb_cv32e40n_apu_responder.sv
// tb_cv32e40n_apu_responder: directed and randomized checks of the APU responder against an in-order queue model.
// A bench-side memory answers the data port with random grant/valid delays.
module tb_cv32e40n_apu_responder;
    import cv32e40n_apu_resp_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
`ifdef APU_RESP_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          fails = 0;
    req_t        q[$];
    logic [31:0] got[$];
    logic [31:0] ref_mem [256];
    logic [31:0] bus_mem [256];
    int          force_gdly = -1;
    int          force_rdly = -1;
    int          gcnt = 0;
    int          rv_cnt = 0;
    int          req_cycles = 0;
    int          sel_cycles = 0;
    bit          bus_own = 1'b0;
    logic [31:0] rd_val = '0;

    always #5 clk = ~clk;

    cv32e40n_apu_responder_if bus ();

    cv32e40n_apu_responder #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .apu   (bus)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    // Reference model, APU side and bench memory; all evaluated mid-cycle.
    always @(negedge clk) begin : mon
        req_t        r;
        logic [31:0] e;
        bit          bad;
        bit          legal;
        if (rst) begin
            q.delete();
            bus_own = 1'b0;
            rv_cnt = 0;
            gcnt = 0;
            bus.data_gnt_i = 1'b0;
            bus.data_rvalid_i = 1'b0;
        end else begin
            if (bus.data_req_o) req_cycles++;
            if (bus.mem_master_sel) sel_cycles++;
            chk("gnt", bus.apu_gnt_o, q.size() < DEPTH);
            if (bus.apu_rvalid_o && q.size() == 0) chk("rvalid_when_empty", bus.apu_rvalid_o, 0);
            else if (bus.apu_rvalid_o) begin
                r = q.pop_front();
                bad = r.op == 2'd3 || (MIS_EN && (r.op == 2'd1 || r.op == 2'd2) && r.a[1:0] != 2'b00);
                e = bad ? 32'h0 : r.op == 2'd0 ? r.a + r.b : r.op == 2'd1 ? ref_mem[r.a[9:2]] : 32'h0;
                if (!bad && r.op == 2'd2) ref_mem[r.a[9:2]] = r.b;
                chk("result", bus.apu_result_o, e);
                chk("flags", 32'(bus.apu_flags_o), 32'(bad));
                got.push_back(bus.apu_result_o);
            end else begin
                chk("idle_result", bus.apu_result_o, 0);
                chk("idle_flags", 32'(bus.apu_flags_o), 0);
            end
            chk("master_sel", bus.mem_master_sel, bus.data_req_o || bus_own);
            if (bus.data_req_o && q.size() == 0) chk("req_when_empty", bus.data_req_o, 0);
            else if (bus.data_req_o) begin
                r = q[0];
                legal = (r.op == 2'd1 || r.op == 2'd2) && !(MIS_EN && r.a[1:0] != 2'b00);
                chk("req_legal", legal, 1);
                chk("addr", bus.data_addr_o, {r.a[31:2], 2'b00});
                chk("we", bus.data_we_o, r.op == 2'd2);
                chk("wdata", bus.data_wdata_o, r.b);
                chk("be", 32'(bus.data_be_o), 32'hF);
            end else chk("bus_idle", |{bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o}, 0);
            if (bus.apu_req_i && bus.apu_gnt_o)
                q.push_back('{op: bus.apu_op_i[1:0], a: bus.apu_operands_i[0], b: bus.apu_operands_i[1]});
            bus.data_gnt_i = 1'b0;
            bus.data_rvalid_i = 1'b0;
            bus.data_rdata_i = $urandom;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i = rd_val;
                    bus_own = 1'b0;
                end
            end else if (bus.data_req_o) begin
                if (!bus_own) begin
                    gcnt = force_gdly >= 0 ? force_gdly : int'($urandom_range(0, 3));
                    bus_own = 1'b1;
                end
                if (gcnt == 0) begin
                    bus.data_gnt_i = 1'b1;
                    if (bus.data_we_o) bus_mem[bus.data_addr_o[9:2]] = bus.data_wdata_o;
                    rd_val = bus_mem[bus.data_addr_o[9:2]];
                    rv_cnt = 1 + (force_rdly >= 0 ? force_rdly : int'($urandom_range(0, 2)));
                end else gcnt--;
            end else if ($urandom_range(0, 3) == 0) bus.data_rvalid_i = 1'b1;
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [APU_WOP_CPU-1:0] o;
        o = APU_WOP_CPU'($urandom);
        o[1:0] = op;
        bus.apu_req_i = v;
        bus.apu_op_i = o;
        bus.apu_operands_i[0] = a;
        bus.apu_operands_i[1] = b;
        bus.apu_operands_i[2] = $urandom;
        bus.apu_flags_i = APU_NDSFLAGS_CPU'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] res, input logic flg);
        bit seen;
        drain();
        @(posedge clk);
        #1;
        drive(1'b1, op, a, b);
        @(posedge clk);
        #1;
        bus.apu_req_i = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.apu_rvalid_o) begin
                seen = 1'b1;
                chk({n, "_latency"}, k, lat);
                chk({n, "_result"}, bus.apu_result_o, res);
                chk({n, "_err"}, bus.apu_flags_o[0], flg);
            end
        end
        if (!seen) chk({n, "_timeout"}, seen, 1);
    endtask

    initial begin
        int acc;
        int rv_after;
        bit found;
        logic [1:0] op;
        int sel;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        ref_mem[8'h40] = 32'hDEADBEEF;
        bus_mem[8'h40] = 32'hDEADBEEF;
        drive(1'b0, 2'd0, 0, 0);
        bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", bus.apu_gnt_o, 1);
        chk("rst_rvalid", bus.apu_rvalid_o, 0);
        chk("rst_result", bus.apu_result_o, 0);
        chk("rst_flags", 32'(bus.apu_flags_o), 0);
        chk("rst_req", bus.data_req_o, 0);
        chk("rst_sel", bus.mem_master_sel, 0);
        chk("rst_bus", |{bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        single("alu_5_7", 2'd0, 32'd5, 32'd7, LAT + 2, 32'd12, 1'b0);
        single("alu_wrap", 2'd0, 32'hFFFF_FFFF, 32'd2, LAT + 2, 32'd1, 1'b0);
        force_gdly = 2;
        force_rdly = 0;
        req_cycles = 0;
        sel_cycles = 0;
        single("load_100", 2'd1, 32'h100, 32'h0, 6, 32'hDEADBEEF, 1'b0);
        chk("load_req_cycles", req_cycles, 3);
        chk("load_sel_cycles", sel_cycles, 4);
        force_gdly = 0;
        single("store_204", 2'd2, 32'h204, 32'hA5A5A5A5, 4, 32'h0, 1'b0);
        chk("store_mem", bus_mem[8'h81], 32'hA5A5A5A5);
        single("load_204", 2'd1, 32'h204, 32'h0, 4, 32'hA5A5A5A5, 1'b0);
        req_cycles = 0;
        single("rsvd", 2'd3, 32'h100, 32'h1, 2, 32'h0, 1'b1);
        chk("rsvd_req_cycles", req_cycles, 0);
        req_cycles = 0;
        single("load_102", 2'd1, 32'h102, 32'h0, MIS_EN ? 2 : 4, MIS_EN ? 32'h0 : 32'hDEADBEEF, MIS_EN);
        chk("load_102_req_cycles", req_cycles, MIS_EN ? 0 : 1);

        // Six back-to-back ALU requests against a four-entry buffer.
        drain();
        got.delete();
        acc = 0;
        drive(1'b1, 2'd0, 32'd1, 32'd10);
        for (int c = 0; c < 60 && acc < 6; c++) begin
            @(negedge clk);
            if (bus.apu_gnt_o) acc++;
            if (c == 4) begin
                chk("b2b_accepts_before_full", acc, 4);
                chk("b2b_gnt_full", bus.apu_gnt_o, 0);
            end
            @(posedge clk);
            #1;
            if (acc < 6) drive(1'b1, 2'd0, 32'(acc + 1), 32'(10 * (acc + 1)));
            else bus.apu_req_i = 1'b0;
        end
        bus.apu_req_i = 1'b0;
        chk("b2b_accepts", acc, 6);
        drain();
        chk("b2b_count", got.size(), 6);
        for (int j = 0; j < 6 && j < got.size(); j++) chk("b2b_order", got[j], 32'(11 * (j + 1)));

        // Reset while a load sits in MEM_WAIT.
        force_gdly = 0;
        force_rdly = 6;
        drive(1'b1, 2'd1, 32'h100, 32'h0);
        @(posedge clk);
        #1;
        bus.apu_req_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = bus_own && !bus.data_req_o && bus.mem_master_sel;
        end
        chk("rst_reached_wait", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rvalid", bus.apu_rvalid_o, 0);
        chk("arst_sel", bus.mem_master_sel, 0);
        chk("arst_req", bus.data_req_o, 0);
        chk("arst_gnt", bus.apu_gnt_o, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rv_after = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.apu_rvalid_o) rv_after++;
        end
        chk("no_rvalid_after_rst", rv_after, 0);
        force_gdly = -1;
        force_rdly = -1;

        // Randomized mix of ops, addresses and request gaps.
        repeat (500) begin
            @(posedge clk);
            #1;
            sel = $urandom_range(0, 9);
            op = sel < 5 ? 2'd0 : sel < 7 ? 2'd1 : sel < 9 ? 2'd2 : 2'd3;
            drive($urandom_range(0, 2) != 0, op, op == 2'd0 ? $urandom : 32'($urandom_range(0, 1023)), $urandom);
        end
        bus.apu_req_i = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cv32e40n_apu_responder.md
# cv32e40n_apu_responder

Parametrised APU-side responder that replaces the single-cycle dummy on the cv32e40p APU port. It buffers up to DEPTH accepted requests in order. Each request executes as an ALU add with configurable latency, or as a load/store on the data memory interface while it owns the memory master select. Results return in order on the APU response channel.

## Interface
Parameters:
- NARGS, default APU_NARGS_CPU: number of operand words.
- WOP, default APU_WOP_CPU: op width; only op[1:0] is decoded.
- NDSFLAGS, default APU_NDSFLAGS_CPU: downstream flag width; flags are ignored.
- NUSFLAGS, default APU_NUSFLAGS_CPU: upstream flag width; must be ≥1.
- LATENCY, default 1: ALU execute cycles, range 1..15.
- DEPTH, default 4: request FIFO entries; a power of 2, range 2..8.

Ports:
- clk_i in 1: the single clock.
- rst_i in 1: asynchronous, active-high reset.
- apu_operands_i in NARGS×32: operand words.
- apu_op_i in WOP: operation.
- apu_flags_i in NDSFLAGS: unused.
- apu_req_i in 1: request valid.
- apu_gnt_o out 1: request accepted.
- apu_rvalid_o out 1: one-cycle result strobe.
- apu_result_o out 32: result word.
- apu_flags_o out NUSFLAGS: result flags; bit0 is the error flag.
- mem_master_sel out 1: high while this block owns the data bus.
- data_req_o, data_we_o out 1: memory request and write enable.
- data_be_o out 4: byte enables.
- data_addr_o, data_wdata_o out 32: address and write data.
- data_gnt_i, data_rvalid_i in 1: memory grant and read-data valid.
- data_rdata_i in 32: memory read data.

## Operation
- Accept rule:
  - apu_gnt_o = !fifo_full, combinational.
  - A request is accepted when apu_req_i && apu_gnt_o.
  - On accept, {op[1:0], operand0, operand1} is pushed into the FIFO.
  - No bypass: a full FIFO blocks the grant even in a pop cycle.
- Op decode on op[1:0]:
  - 0 ALU: result = operand0 + operand1, mod 2^32.
  - 1 LOAD: read the word at operand0; result = data_rdata_i.
  - 2 STORE: write operand1 to operand0; result = 0.
  - 3 reserved: result = 0, flags bit0 = 1, no bus access.
- FSM states: IDLE, EXEC, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, decode the head.
  - ALU: go to EXEC with cnt = LATENCY−1.
  - LOAD/STORE: go to MEM_REQ.
  - Reserved: go to RESP.
- EXEC: if cnt == 0 go to RESP, else decrement cnt.
- MEM_REQ:
  - Drive data_req_o=1, data_addr_o={operand0[31:2],2'b00}, data_be_o=4'hF.
  - Drive data_we_o=(op==STORE) and data_wdata_o=operand1.
  - Hold all of these stable until data_gnt_i, then go to MEM_WAIT.
- MEM_WAIT: on data_rvalid_i, capture data_rdata_i (LOAD only) and go to RESP.
- mem_master_sel = 1 exactly in MEM_REQ and MEM_WAIT.
- RESP:
  - apu_rvalid_o=1 with result and flags.
  - Pop the FIFO head and go to IDLE.
  - There is no response back-pressure.
- Outside MEM_REQ, every data_* output is 0.
- data_rvalid_i outside MEM_WAIT is ignored.
- apu_result_o and apu_flags_o are 0 whenever apu_rvalid_o=0.

## Timing
- Reset values:
  - Every output is 0, except apu_gnt_o, which is 1 (FIFO empty).
  - FSM is in IDLE; FIFO pointers and count are 0; cnt is 0.
- With an accept in cycle T into an empty FIFO:
  - ALU: rvalid in cycle T+LATENCY+2.
  - LOAD/STORE with gnt in T+2 and rvalid in T+3: rvalid in T+4.
  - Reserved: rvalid in T+2.
- Throughput:
  - Back-to-back ALU ops produce one response every LATENCY+2 cycles.
  - The FIFO absorbs requests meanwhile.
- Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Reset asserted mid-operation:
  - Reset is asynchronous and immediate.
  - The FIFO is flushed, data_req_o drops even if ungranted, mem_master_sel goes to 0, and no response is produced.
  - Any in-flight bus transaction is abandoned; the system must reset memory too.
- Responses are strictly in acceptance order.

## Configuration
- APU_RESP_MISALIGN_CHK_EN defined:
  - A LOAD/STORE with operand0[1:0] != 0 skips the bus (IDLE→RESP).
  - It responds with result = 0 and flags bit0 = 1, latency as reserved op.
- Undefined:
  - Address bits [1:0] are silently forced to 0 and the access proceeds.

## Structure
- Package cv32e40n_apu_resp_pkg holds:
  - the op enum (ALU, LOAD, STORE, RSVD);
  - the state enum;
  - a packed FIFO entry struct {op, op0, op1};
  - the constant ERR_FLAG_BIT = 0.
- Sub-module cv32e40n_apu_req_fifo: a synchronous FIFO, DEPTH entries, with full, empty and count outputs, and the same clock and reset.

## Test plan
- ALU, LATENCY=3: operands 5 and 7 accepted at T → rvalid at T+5, result 12, flags 0.
- LOAD at 0x100, gnt delayed 2 cycles, rdata 0xDEADBEEF:
  - data_req, address and be are held for 3 cycles, with mem_master_sel=1 throughout.
  - Result 0xDEADBEEF.
- STORE 0xA5A5A5A5 to 0x204: data_we=1, wdata 0xA5A5A5A5, be F; result 0.
- DEPTH=4, issue 6 ALU reqs back-to-back:
  - gnt drops after 4 accepts (5 if the first has already been popped).
  - All 6 results return in order.
- Op 3, and LOAD at 0x102 with APU_RESP_MISALIGN_CHK_EN defined: flags bit0=1, result 0, no data_req.
- Assert rst_i during MEM_WAIT: outputs reach reset values immediately, no rvalid afterwards, and the FIFO is empty.
